// File: rtl/posit_pio_pkg.sv
// Shared types and defaults for the HPS operand/result PIO responder.
package posit_pio_pkg;

  localparam int unsigned WIDTH_DEF          = 32;
  localparam int unsigned SETTLE_CYCLES_DEF  = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;
  localparam int unsigned NAR_MAX_W          = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    ISSUE    = 2'd2,
    WAIT_RES = 2'd3
  } state_t;

  // Posit Not-a-Real: sign bit set, all other bits clear (caller truncates to width).
  function automatic logic [NAR_MAX_W-1:0] nar(input int unsigned width);
    logic [NAR_MAX_W-1:0] v;
    v = '0;
    v[6'(width - 1)] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/posit_pio_settle.sv
// Operand settle detector: shadow of last issued pair, change detector and settle counter.
// Emits a one-cycle capture strobe once the operands have been quiet long enough.
module posit_pio_settle
  import posit_pio_pkg::*;
#(
  parameter int unsigned WIDTH         = WIDTH_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idle_i,
  input  logic             settle_i,
  input  logic [WIDTH-1:0] num1_i,
  input  logic [WIDTH-1:0] num2_i,
  output logic             start_c_o,
  output logic             capture_c_o
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic [WIDTH-1:0] prev_a_q, prev_b_q;
  logic [WIDTH-1:0] shadow_a_q, shadow_b_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             changed_c;

  assign changed_c   = {num1_i, num2_i} != {prev_a_q, prev_b_q};
  assign start_c_o   = idle_i && ({num1_i, num2_i} != {shadow_a_q, shadow_b_q});
  assign capture_c_o = settle_i && (cnt_q == '0) && !changed_c;

  // Any change restarts the settle window; the counter saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start_c_o) begin
      cnt_d = CNT_W'(SETTLE_CYCLES - 1);
    end else if (settle_i) begin
      if (changed_c) begin
        cnt_d = CNT_W'(SETTLE_CYCLES - 1);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_a_q   <= '0;
      prev_b_q   <= '0;
      shadow_a_q <= '0;
      shadow_b_q <= '0;
      cnt_q      <= '0;
    end else begin
      prev_a_q <= num1_i;
      prev_b_q <= num2_i;
      cnt_q    <= cnt_d;
      if (capture_c_o) begin
        shadow_a_q <= num1_i;
        shadow_b_q <= num2_i;
      end
    end
  end

endmodule

// File: rtl/posit_pio_responder.sv
// FPGA-side responder bridging the num1/num2/result PIO exports to a posit core.
// Optional result timeout (NaR on expiry) enabled by defining POSIT_PIO_TIMEOUT_EN.
module posit_pio_responder
  import posit_pio_pkg::*;
#(
  parameter int unsigned WIDTH          = WIDTH_DEF,
  parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] num1_i,
  input  logic [WIDTH-1:0] num2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             op_valid_o,
  input  logic             op_ready_i,
  output logic [WIDTH-1:0] op_a_o,
  output logic [WIDTH-1:0] op_b_o,
  input  logic             res_valid_i,
  output logic             res_ready_o,
  input  logic [WIDTH-1:0] res_data_i,
  output logic             busy_o
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             op_valid_q, op_valid_d;
  logic             res_ready_q, res_ready_d;
  logic             busy_q, busy_d;
  logic             start_c, capture_c;

`ifdef POSIT_PIO_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
`endif

  posit_pio_settle #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk         (clk),
    .rst_n       (reset_n),
    .idle_i      (state_q == IDLE),
    .settle_i    (state_q == SETTLE),
    .num1_i      (num1_i),
    .num2_i      (num2_i),
    .start_c_o   (start_c),
    .capture_c_o (capture_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
`ifdef POSIT_PIO_TIMEOUT_EN
    timer_d  = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_c) state_d = SETTLE;
      end
      SETTLE: begin
        if (capture_c) begin
          op_a_d  = num1_i;
          op_b_d  = num2_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (op_valid_q && op_ready_i) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (res_valid_i) begin
          result_d = res_data_i;
          state_d  = IDLE;
`ifdef POSIT_PIO_TIMEOUT_EN
        end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          result_d = WIDTH'(nar(WIDTH));
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    op_valid_d  = (state_d == ISSUE);
    res_ready_d = (state_d == WAIT_RES);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      op_valid_q  <= 1'b0;
      res_ready_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef POSIT_PIO_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      result_q    <= result_d;
      op_valid_q  <= op_valid_d;
      res_ready_q <= res_ready_d;
      busy_q      <= busy_d;
`ifdef POSIT_PIO_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  assign result_o    = result_q;
  assign op_valid_o  = op_valid_q;
  assign op_a_o      = op_a_q;
  assign op_b_o      = op_b_q;
  assign res_ready_o = res_ready_q;
  assign busy_o      = busy_q;

endmodule
